membus_ram_responder: RTL and testbench



---
 rtl/membus_ram_responder_pkg.sv | 15 +
 rtl/membus_ram_responder_ram_array.sv | 26 ++
 rtl/membus_ram_responder.sv | 131 +++++++++++++
 tb/tb_membus_ram_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/membus_ram_responder_pkg.sv
// Shared definitions for the memory-bus RAM responder: bus word width,
// wait-state counter width and the responder state encoding.
package membus_ram_responder_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/membus_ram_responder_ram_array.sv
// Single-port synchronous RAM, one 32-bit word per address.
// A read during a write returns the old contents.
module membus_ram_array
    import membus_ram_responder_pkg::*;
#(
    parameter int AW        = 10,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] mem [2**AW];

    // Write port and registered read port sharing one address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/membus_ram_responder.sv
// Memory-bus responder: decodes an address window, inserts WAIT_CYCLES wait
// states, then performs one RAM access and holds the completion (ready for a
// read, ack for a write) until the master drops its request.
module membus_ram_responder
    import membus_ram_responder_pkg::*;
#(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_data_rd,
    input  logic              bus_data_wr,
    input  logic [31:0]       bus_data_address,
    input  logic [WORD_W-1:0] bus_data_out,
    output logic [WORD_W-1:0] bus_data_in,
    output logic              bus_data_in_ready,
    output logic              bus_data_ack,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              req;
    logic              hit;
    logic              ram_we;
    logic [WORD_W-1:0] ram_dout;

    assign req    = bus_data_rd | bus_data_wr;
    assign hit    = (bus_data_address[31:AW] == BASE[31:AW]);
    assign ram_we = (state_q == ST_ACCESS) && wr_q;

    // Next-state, transfer latching and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (req && hit) begin
                    addr_d  = bus_data_address[AW-1:0];
                    wdata_d = bus_data_out;
                    wr_d    = bus_data_wr;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped request before the access abandons the transfer
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_RESP) && !wr_d;
        ack_d   = (state_d == ST_RESP) && wr_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // Control state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Latched transfer address, write data and direction
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
    end

    membus_ram_array #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .addr (addr_q),
        .we   (ram_we),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    // The read word comes from the RAM output register, which holds while the
    // latched address is unchanged; masking with ready keeps the bus at 0.
    assign bus_data_in       = ready_q ? ram_dout : '0;
    assign bus_data_in_ready = ready_q;
    assign bus_data_ack      = ack_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_membus_ram_responder.sv
// Bench: four responders with disjoint 1K-word windows share one bus, each
// with a different wait-state count; a per-instance word array is the model.
module tb_membus_ram_responder;

    logic        clk;
    logic        rst;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;

    logic [3:0][31:0] din_w;
    logic [3:0]       rdy_w;
    logic [3:0]       ack_w;
    logic [3:0]       busy_w;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem_m [4][1024];
    bit          known [4][1024];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 15 : 4;
        membus_ram_responder #(
            .AW          (10),
            .BASE        (32'(g) << 10),
            .WAIT_CYCLES (WC),
            .INIT_FILE   ("")
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .bus_data_rd       (bus_rd),
            .bus_data_wr       (bus_wr),
            .bus_data_address  (bus_addr),
            .bus_data_out      (bus_wdata),
            .bus_data_in       (din_w[g]),
            .bus_data_in_ready (rdy_w[g]),
            .bus_data_ack      (ack_w[g]),
            .busy              (busy_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 15 : 4;
    endfunction

    function automatic logic [34:0] obs(input int i);
        return {busy_w[i], rdy_w[i], ack_w[i], din_w[i]};
    endfunction

    task automatic chk(input string tag, input logic [34:0] o, input logic [34:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed={busy,rdy,ack,din}=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_all_idle(input string tag);
        for (int j = 0; j < 4; j++) chk(tag, obs(j), 35'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer: latency WAIT_CYCLES+2, completion held for
    // `hold` extra cycles, then the request is dropped.
    task automatic xfer(input int inst, input int idx, input bit rd, input bit wr,
                        input logic [31:0] wd, input int hold);
        int          lat;
        logic [31:0] exp_d;
        logic [34:0] exp_v;
        lat       = wc_of(inst) + 2;
        exp_d     = wr ? 32'h0 : mem_m[inst][idx];
        bus_rd    = rd;
        bus_wr    = wr;
        bus_addr  = 32'(inst * 1024 + idx);
        bus_wdata = wd;
        for (int k = 1; k <= lat + hold; k++) begin
            tick();
            if (k == 1) begin
                bus_addr[9:0] = 10'($urandom);
                bus_wdata     = $urandom;
            end
            if (k < lat) exp_v = {1'b1, 34'h0};
            else         exp_v = {1'b1, !wr, wr, exp_d};
            chk(wr ? "wr_xfer" : "rd_xfer", obs(inst), exp_v);
            for (int j = 0; j < 4; j++)
                if (j != inst) chk("other_window_quiet", obs(j), 35'h0);
        end
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        tick();
        chk_all_idle("after_drop");
        if (wr) begin
            mem_m[inst][idx] = wd;
            known[inst][idx] = 1'b1;
        end
    endtask

    initial begin
        int inst, idx, op, hold, gap;
        rst = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) tick();
        chk_all_idle("reset_state");
        rst = 1'b1;

        // Write then read, one wait state
        xfer(0, 5, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
        xfer(0, 5, 1'b1, 1'b0, 32'h0, 0);

        // Zero and maximum wait states
        xfer(1, 9, 1'b0, 1'b1, 32'hCAFE_0001, 0);
        xfer(1, 9, 1'b1, 1'b0, 32'h0, 0);
        xfer(2, 9, 1'b0, 1'b1, 32'hCAFE_0002, 0);
        xfer(2, 9, 1'b1, 1'b0, 32'h0, 0);

        // Window decode: 0x012 belongs to window 0, 0x412 to window 1
        xfer(0, 18, 1'b0, 1'b1, 32'h1111_2222, 0);
        xfer(1, 18, 1'b0, 1'b1, 32'h3333_4444, 0);
        xfer(0, 18, 1'b1, 1'b0, 32'h0, 17);
        xfer(1, 18, 1'b1, 1'b0, 32'h0, 0);

        // Abort in WAIT on the four-wait-state responder
        xfer(3, 7, 1'b0, 1'b1, 32'h0BAD_F00D, 0);
        bus_wr = 1'b1; bus_addr = 32'(3 * 1024 + 7); bus_wdata = 32'h1234_5678;
        tick();
        chk("abort_wait_c1", obs(3), {1'b1, 34'h0});
        tick();
        chk("abort_wait_c2", obs(3), {1'b1, 34'h0});
        bus_wr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_idle", obs(3), 35'h0);
        end
        xfer(3, 7, 1'b1, 1'b0, 32'h0, 0);

        // Held read and simultaneous rd+wr
        xfer(0, 5, 1'b1, 1'b0, 32'h0, 10);
        xfer(0, 3, 1'b1, 1'b1, 32'hA5A5_A5A5, 0);
        xfer(0, 3, 1'b1, 1'b0, 32'h0, 0);

        // Reset asserted while the read completion is showing
        bus_rd = 1'b1; bus_addr = 32'(5);
        tick();
        tick();
        tick();
        chk("pre_reset_resp", obs(0), {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF});
        rst = 1'b0; bus_rd = 1'b0;
        tick();
        chk_all_idle("reset_mid_resp");
        rst = 1'b1;
        tick();
        chk_all_idle("post_reset_idle");
        xfer(0, 5, 1'b1, 1'b0, 32'h0, 0);
        xfer(3, 7, 1'b1, 1'b0, 32'h0, 0);

        // Randomized traffic across all windows
        for (int n = 0; n < 60; n++) begin
            inst = $urandom_range(0, 3);
            idx  = $urandom_range(0, 15);
            op   = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            if (op == 0 && !known[inst][idx]) op = 1;
            xfer(inst, idx, (op != 1), (op != 0), $urandom, hold);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                tick();
                chk_all_idle("gap_idle");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
